// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : D-stage hazard unit for a 3-stage D/X/W pipeline: forwarding
//             selects, load-use stall/bubble, redirect flush, perf counters.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_d,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_d,
    input  logic             if_rs1_d,
    input  logic             if_rs2_d,
    input  logic             regwen_d,
    input  logic [1:0]       memtoreg_d,
    input  logic             redirect_x,
    output logic             stall,
    output logic             bubble_x,
    output logic             kill_d,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0]       c_ST_RUN    = 1'b0;
    localparam logic [0:0]       c_ST_FLUSH  = 1'b1;
    localparam logic [1:0]       c_FCNT_INIT = 2'(FLUSH_CYCLES - 1);
    localparam bit               c_MULTI     = (FLUSH_CYCLES > 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_x_v, r_x_wen, r_x_ld;
    logic [4:0]       r_x_rd;
    logic             r_w_v, r_w_wen;
    logic [4:0]       r_w_rd;
    logic [0:0]       r_state;
    logic [1:0]       r_fcnt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    logic w_hx1, w_hx2, w_hw1, w_hw2;
    logic w_run, w_accept, w_luse, w_stall, w_kill;

    // x0 is hardwired zero, so it can never be a producer
    assign w_hx1 = r_x_v & r_x_wen & (r_x_rd == rs1_d) & (rs1_d != 5'd0);
    assign w_hx2 = r_x_v & r_x_wen & (r_x_rd == rs2_d) & (rs2_d != 5'd0);
    assign w_hw1 = r_w_v & r_w_wen & (r_w_rd == rs1_d) & (rs1_d != 5'd0);
    assign w_hw2 = r_w_v & r_w_wen & (r_w_rd == rs2_d) & (rs2_d != 5'd0);

    assign w_run    = (r_state == c_ST_RUN);
    assign w_accept = w_run & redirect_x;
    assign w_kill   = w_accept | ~w_run;
    assign w_luse   = valid_d & r_x_ld & ((if_rs1_d & w_hx1) | (if_rs2_d & w_hx2));
    // A redirect squashes D anyway, so stalling it would only waste a cycle
    assign w_stall  = w_luse & ~redirect_x & w_run;

    assign stall     = w_stall;
    assign bubble_x  = w_stall;
    assign kill_d    = w_kill;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    always_comb begin
        fwd_a = 2'd0;
        if (if_rs1_d & w_hx1 & ~r_x_ld)
            fwd_a = 2'd1;
        else if (if_rs1_d & w_hw1)
            fwd_a = 2'd2;
    end

    always_comb begin
        fwd_b = 2'd0;
        if (if_rs2_d & w_hx2 & ~r_x_ld)
            fwd_b = 2'd1;
        else if (if_rs2_d & w_hw2)
            fwd_b = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_v       <= 1'b0;
            r_x_wen     <= 1'b0;
            r_x_ld      <= 1'b0;
            r_x_rd      <= 5'd0;
            r_w_v       <= 1'b0;
            r_w_wen     <= 1'b0;
            r_w_rd      <= 5'd0;
            r_state     <= c_ST_RUN;
            r_fcnt      <= 2'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_w_v   <= r_x_v;
            r_w_wen <= r_x_wen;
            r_w_rd  <= r_x_rd;
            r_x_v   <= valid_d & ~w_stall & ~w_kill;
            r_x_wen <= regwen_d;
            r_x_rd  <= rd_d;
            r_x_ld  <= (memtoreg_d == 2'd0);

            if (w_stall)
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            if (w_accept)
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;

            case (r_state)
                c_ST_RUN: begin
                    if (w_accept && c_MULTI) begin
                        r_state <= c_ST_FLUSH;
                        r_fcnt  <= c_FCNT_INIT;
                    end
                end
                default: begin
                    r_fcnt <= r_fcnt - 2'd1;
                    if (r_fcnt == 2'd1)
                        r_state <= c_ST_RUN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Scoreboard bench for hazard_ctrl against an in-flight list model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int c_FC = 2;
    localparam int c_CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_d, if_rs1_d, if_rs2_d, regwen_d, redirect_x;
    logic [4:0]      rs1_d, rs2_d, rd_d;
    logic [1:0]      memtoreg_d;
    logic            stall, bubble_x, kill_d;
    logic [1:0]      fwd_a, fwd_b;
    logic [c_CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.FLUSH_CYCLES(c_FC), .CNT_W(c_CW)) dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rd_d(rd_d), .if_rs1_d(if_rs1_d), .if_rs2_d(if_rs2_d), .regwen_d(regwen_d),
        .memtoreg_d(memtoreg_d), .redirect_x(redirect_x), .stall(stall),
        .bubble_x(bubble_x), .kill_d(kill_d), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] rs1, rs2, rd;
        bit       u1, u2, wen;
        bit [1:0] mtr;
    } instr_t;

    typedef struct { bit v; bit [4:0] rd; bit wen; bit ld; } flight_t;

    typedef struct {
        bit stall, kill;
        int fa, fb, sc, fc;
    } exp_t;

    // flight[0] is the instruction now in X, flight[1] the one in W
    flight_t flight[$];
    int      kill_rem, n_stall, n_flush;
    exp_t    exp_q[$];
    int      n_cmp = 0, n_bad = 0;

    function automatic void model_reset();
        flight_t z;
        z = '{v: 0, rd: 0, wen: 0, ld: 0};
        flight   = {z, z};
        kill_rem = 0;
        n_stall  = 0;
        n_flush  = 0;
    endfunction

    function automatic bit writes(int age, bit [4:0] r);
        return (r != 0) && flight[age].v && flight[age].wen && (flight[age].rd == r);
    endfunction

    function automatic int src(bit used, bit [4:0] r);
        if (used && writes(0, r) && !flight[0].ld) return 1;
        if (used && writes(1, r)) return 2;
        return 0;
    endfunction

    task automatic drive(instr_t i, bit redir, bit r);
        exp_t    e;
        flight_t nf;
        bit      luse, killd;
        valid_d = i.v;   rs1_d = i.rs1; rs2_d = i.rs2; rd_d = i.rd;
        if_rs1_d = i.u1; if_rs2_d = i.u2; regwen_d = i.wen; memtoreg_d = i.mtr;
        redirect_x = redir; rst = r;

        luse  = i.v && flight[0].ld &&
                ((i.u1 && writes(0, i.rs1)) || (i.u2 && writes(0, i.rs2)));
        killd = (kill_rem > 0) || redir;
        e.stall = luse && !redir && (kill_rem == 0);
        e.kill  = killd;
        e.fa    = src(i.u1, i.rs1);
        e.fb    = src(i.u2, i.rs2);
        e.sc    = n_stall;
        e.fc    = n_flush;
        exp_q.push_back(e);

        if (r) begin
            model_reset();
        end else begin
            nf = '{v: i.v && !e.stall && !killd, rd: i.rd, wen: i.wen, ld: (i.mtr == 0)};
            flight.push_front(nf);
            void'(flight.pop_back());
            if (e.stall) n_stall = (n_stall + 1) % (1 << c_CW);
            if (kill_rem > 0) begin
                kill_rem--;
            end else if (redir) begin
                n_flush  = (n_flush + 1) % (1 << c_CW);
                kill_rem = c_FC - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t mk(bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2,
                                  bit u1, bit u2, bit wen, bit [1:0] mtr);
        return '{v: 1, rs1: rs1, rs2: rs2, rd: rd, u1: u1, u2: u2, wen: wen, mtr: mtr};
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall",     int'(stall),     int'(e.stall));
            check("bubble_x",  int'(bubble_x),  int'(e.stall));
            check("kill_d",    int'(kill_d),    int'(e.kill));
            check("fwd_a",     int'(fwd_a),     e.fa);
            check("fwd_b",     int'(fwd_b),     e.fb);
            check("stall_cnt", int'(stall_cnt), e.sc);
            check("flush_cnt", int'(flush_cnt), e.fc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t nop, add5, use55, use50, lw5, use51, lw0, use00, sw5, ri;
        nop   = '{v: 0, rs1: 0, rs2: 0, rd: 0, u1: 0, u2: 0, wen: 0, mtr: 1};
        add5  = mk(5, 1, 2, 1, 1, 1, 1);
        use55 = mk(6, 5, 5, 1, 1, 1, 1);
        use50 = mk(7, 5, 0, 1, 1, 1, 1);
        lw5   = mk(5, 1, 0, 1, 0, 1, 0);
        use51 = mk(6, 5, 1, 1, 1, 1, 1);
        lw0   = mk(0, 1, 0, 1, 0, 1, 0);
        use00 = mk(6, 0, 0, 1, 1, 1, 1);
        sw5   = mk(0, 1, 5, 1, 1, 0, 1);

        valid_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0; if_rs1_d = 0; if_rs2_d = 0;
        regwen_d = 0; memtoreg_d = 0; redirect_x = 0; rst = 1;
        @(posedge clk); @(posedge clk); #1;
        model_reset();

        drive(nop, 0, 0);                                          // reset state
        drive(add5, 0, 0); drive(use55, 0, 0); drive(use50, 0, 0); // X then W forward
        drive(nop, 0, 0); drive(nop, 0, 0);
        drive(lw5, 0, 0); drive(use51, 0, 0); drive(use51, 0, 0);  // load-use stall
        drive(lw0, 0, 0); drive(use00, 0, 0);                      // x0 never a hazard
        drive(add5, 0, 0); drive(sw5, 0, 0);                       // store-data forward
        drive(nop, 1, 0); drive(nop, 1, 0); drive(nop, 0, 0);      // redirect, 2nd ignored
        drive(lw5, 0, 0); drive(use51, 1, 0);                      // redirect beats luse
        drive(nop, 0, 0); drive(nop, 1, 0); drive(nop, 0, 1);      // reset mid-FLUSH
        drive(nop, 0, 0);
        drive(lw5, 0, 0); drive(use51, 0, 1); drive(use51, 0, 0);  // reset mid-stall
        for (int k = 0; k < 17; k++) begin                         // counter wrap
            drive(lw5, 0, 0); drive(use51, 0, 0); drive(use51, 0, 0);
        end

        for (int k = 0; k < 600; k++) begin
            ri.v   = ($urandom_range(0, 9) != 0);
            ri.rs1 = 5'($urandom_range(0, 3));
            ri.rs2 = 5'($urandom_range(0, 3));
            ri.rd  = 5'($urandom_range(0, 3));
            ri.u1  = 1'($urandom_range(0, 1));
            ri.u2  = 1'($urandom_range(0, 1));
            ri.wen = ($urandom_range(0, 3) != 0);
            ri.mtr = 2'($urandom_range(0, 2));
            drive(ri, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
        end
        drive(nop, 0, 0);

        @(posedge clk); #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
